// File: rtl/trade_order_scheduler.sv
// Round-robin arbiter that turns per-strategy buy/sell decisions into one
// order stream, gated by a net position limit and a post-order cooldown.
module trade_order_scheduler #(
  parameter int NUM_SRC   = 4,
  parameter int POS_W     = 8,
  parameter int POS_LIMIT = 8,
  parameter int COOLDOWN  = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0]         src_buy,
  input  logic [NUM_SRC-1:0]         src_sell,
  output logic                       order_valid,
  input  logic                       order_ready,
  output logic                       order_side,
  output logic [$clog2(NUM_SRC)-1:0] order_src,
  output logic signed [POS_W-1:0]    position,
  output logic                       reject_pulse,
  output logic [CNT_W-1:0]           reject_count,
  output logic                       busy
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic signed [POS_W-1:0] LIM_P = POS_W'(POS_LIMIT);
  localparam logic signed [POS_W-1:0] LIM_N = -LIM_P;
  localparam logic signed [POS_W-1:0] ONE   = POS_W'(1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [IDX_W:0]  NSRC    = (IDX_W+1)'(NUM_SRC);

  typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;

  state_t                   state_reg, state_next;
  logic [NUM_SRC-1:0]       pending_reg, pending_next;
  logic [NUM_SRC-1:0]       side_reg, side_next;
  logic [NUM_SRC-1:0]       elig, drop, grant_clr;
  logic [IDX_W-1:0]         last_grant_reg, order_src_reg, grant_idx;
  logic                     order_side_reg, grant_found;
  logic signed [POS_W-1:0]  position_reg;
  logic                     reject_pulse_reg;
  logic [CNT_W-1:0]         reject_count_reg;
  logic [CD_W-1:0]          cd_reg;
  logic [IDX_W:0]           cand, drop_cnt;
  logic [CNT_W:0]           rej_sum;
  logic                     buy_ok, sell_ok, hs;

  assign buy_ok  = position_reg < LIM_P;
  assign sell_ok = position_reg > LIM_N;
  assign hs      = (state_reg == ISSUE) && order_ready;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic set_req;
    assign set_req           = src_valid[gi] & (src_buy[gi] ^ src_sell[gi]);
    assign elig[gi]          = pending_reg[gi] & (side_reg[gi] ? buy_ok : sell_ok);
    assign drop[gi]          = (state_reg == IDLE) & pending_reg[gi] & ~elig[gi];
    // a fresh request always survives a same-cycle grant or reject clear
    assign pending_next[gi]  = set_req | (pending_reg[gi] & ~grant_clr[gi] & ~drop[gi]);
    assign side_next[gi]     = set_req ? src_buy[gi] : side_reg[gi];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, last_grant_reg} + (IDX_W+1)'(k);
      if (cand >= NSRC) cand = cand - NSRC;
      if (!grant_found && elig[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) drop_cnt = drop_cnt + (IDX_W+1)'(drop[i]);
    rej_sum = {1'b0, reject_count_reg} + (CNT_W+1)'(drop_cnt);
  end

  always_comb begin
    state_next = state_reg;
    grant_clr  = '0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next           = ISSUE;
          grant_clr[grant_idx] = 1'b1;
        end
      end
      ISSUE: begin
        if (order_ready) state_next = (COOLDOWN == 0) ? IDLE : COOL;
      end
      COOL: begin
        if (cd_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      pending_reg      <= '0;
      side_reg         <= '0;
      last_grant_reg   <= IDX_W'(NUM_SRC - 1);
      order_src_reg    <= '0;
      order_side_reg   <= 1'b0;
      position_reg     <= '0;
      reject_pulse_reg <= 1'b0;
      reject_count_reg <= '0;
      cd_reg           <= '0;
    end else begin
      state_reg        <= state_next;
      pending_reg      <= pending_next;
      side_reg         <= side_next;
      reject_pulse_reg <= |drop;
      if (|drop) reject_count_reg <= rej_sum[CNT_W] ? '1 : rej_sum[CNT_W-1:0];
      if (state_reg == IDLE && grant_found) begin
        order_src_reg  <= grant_idx;
        order_side_reg <= side_reg[grant_idx];
      end
      if (hs) begin
        position_reg   <= order_side_reg ? position_reg + ONE : position_reg - ONE;
        last_grant_reg <= order_src_reg;
        cd_reg         <= CD_LOAD;
      end else if (state_reg == COOL) begin
        cd_reg <= cd_reg - CD_W'(1);
      end
    end
  end

  assign order_valid  = (state_reg == ISSUE);
  assign order_side   = order_side_reg;
  assign order_src    = order_src_reg;
  assign position     = position_reg;
  assign reject_pulse = reject_pulse_reg;
  assign reject_count = reject_count_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_trade_order_scheduler.sv
// Directed bench for trade_order_scheduler with default parameters
// (NUM_SRC=4, POS_LIMIT=8, COOLDOWN=4).
module tb_trade_order_scheduler;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        src_valid = '0, src_buy = '0, src_sell = '0;
  logic              order_valid, order_ready = 1'b0, order_side;
  logic [1:0]        order_src;
  logic signed [7:0] position;
  logic              reject_pulse;
  logic [15:0]       reject_count;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int t, busy_n, found;
  int ord_t[3];
  int ord_s[3];

  always #5 clk = ~clk;

  trade_order_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_buy(src_buy), .src_sell(src_sell),
    .order_valid(order_valid), .order_ready(order_ready),
    .order_side(order_side), .order_src(order_src),
    .position(position), .reject_pulse(reject_pulse),
    .reject_count(reject_count), .busy(busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] s);
    src_valid = v;
    src_buy   = b;
    src_sell  = s;
  endtask

  task automatic do_reset();
    drive(4'b0, 4'b0, 4'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  // single order from one source, returns once the scheduler is idle again
  task automatic one_order(input logic [3:0] v, input logic buy);
    drive(v, buy ? v : 4'b0, buy ? 4'b0 : v);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    tick();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset state and single-order latency
    do_reset();
    chk("rst_valid", int'(order_valid), 0);
    chk("rst_position", int'(position), 0);
    chk("rst_rejcnt", int'(reject_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_src", int'(order_src), 0);
    order_ready = 1'b1;
    drive(4'b0001, 4'b0001, 4'b0000);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    chk("c1_valid", int'(order_valid), 0);
    tick();
    chk("c2_valid", int'(order_valid), 1);
    chk("c2_side", int'(order_side), 1);
    chk("c2_src", int'(order_src), 0);
    chk("c2_busy", int'(busy), 1);
    busy_n = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!busy) break;
      busy_n++;
    end
    chk("busy_cycles", busy_n, 5);
    chk("pos_after_1", int'(position), 1);

    // ---- round robin over simultaneous requests 0,1,2
    do_reset();
    order_ready = 1'b1;
    drive(4'b0111, 4'b0111, 4'b0000);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    t = 1;
    for (int n = 0; n < 3; n++) begin
      ord_t[n] = -1;
      ord_s[n] = -1;
      for (int k = 0; k < 30; k++) begin
        tick();
        t++;
        if (order_valid) begin
          ord_t[n] = t;
          ord_s[n] = int'(order_src);
          break;
        end
      end
    end
    chk("rr_t0", ord_t[0], 2);
    chk("rr_s0", ord_s[0], 0);
    chk("rr_t1", ord_t[1], 8);
    chk("rr_s1", ord_s[1], 1);
    chk("rr_t2", ord_t[2], 14);
    chk("rr_s2", ord_s[2], 2);
    wait_idle();
    chk("rr_pos", int'(position), 3);
    drive(4'b1001, 4'b1001, 4'b0000);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    tick();
    chk("rr_next_src", int'(order_src), 3);
    chk("rr_next_valid", int'(order_valid), 1);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (order_valid) begin
        found = 1;
        break;
      end
    end
    chk("rr_wrap_found", found, 1);
    chk("rr_wrap_src", int'(order_src), 0);
    wait_idle();
    chk("rr_pos5", int'(position), 5);

    // ---- backpressure: order held stable while ready is low
    do_reset();
    order_ready = 1'b0;
    drive(4'b0100, 4'b0000, 4'b0100);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", int'(order_valid), 1);
      chk("bp_src", int'(order_src), 2);
      chk("bp_side", int'(order_side), 0);
      chk("bp_pos", int'(position), 0);
      tick();
    end
    order_ready = 1'b1;
    tick();
    chk("bp_pos_after", int'(position), -1);
    chk("bp_valid_after", int'(order_valid), 0);

    // ---- position limit: buy rejected at +8, sell granted
    do_reset();
    order_ready = 1'b1;
    for (int n = 0; n < 8; n++) one_order(4'b0001, 1'b1);
    chk("lim_pos8", int'(position), 8);
    drive(4'b0110, 4'b0010, 4'b0100);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    chk("lim_pulse_pre", int'(reject_pulse), 0);
    tick();
    chk("lim_pulse", int'(reject_pulse), 1);
    chk("lim_rejcnt", int'(reject_count), 1);
    chk("lim_valid", int'(order_valid), 1);
    chk("lim_src", int'(order_src), 2);
    chk("lim_side", int'(order_side), 0);
    tick();
    chk("lim_pulse_end", int'(reject_pulse), 0);
    chk("lim_pos7", int'(position), 7);

    // ---- buy and sell together is ignored
    wait_idle();
    drive(4'b0010, 4'b0010, 4'b0010);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    tick();
    tick();
    chk("both_busy", int'(busy), 0);
    chk("both_valid", int'(order_valid), 0);
    chk("both_rejcnt", int'(reject_count), 1);

    // ---- re-request in the grant cycle stays pending and reissues
    drive(4'b1000, 4'b0000, 4'b1000);
    tick();
    tick();
    drive(4'b0, 4'b0, 4'b0);
    chk("rereq_valid", int'(order_valid), 1);
    chk("rereq_src", int'(order_src), 3);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (order_valid) begin
        found = 1;
        break;
      end
    end
    chk("rereq_found", found, 1);
    chk("rereq_src2", int'(order_src), 3);
    chk("rereq_side2", int'(order_side), 0);
    wait_idle();
    chk("rereq_pos", int'(position), 5);
    tick();
    tick();
    chk("rereq_no_third", int'(busy), 0);

    // ---- asynchronous reset while an order is presented
    order_ready = 1'b0;
    drive(4'b0010, 4'b0010, 4'b0000);
    tick();
    drive(4'b0, 4'b0, 4'b0);
    tick();
    chk("ar_valid_pre", int'(order_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(order_valid), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_pos", int'(position), 0);
    chk("ar_rejcnt", int'(reject_count), 0);
    tick();
    rst_n = 1'b1;
    order_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("ar_post_valid", int'(order_valid), 0);
    chk("ar_post_busy", int'(busy), 0);
    chk("ar_post_pos", int'(position), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
